// File: rtl/corefifo_gray_codec_pipe.sv
// Pipelined Gray/binary pointer converter with elastic valid/ready stages.
// Also monitors successive Gray inputs for steps that change more than one bit.
module corefifo_gray_codec_pipe #(
  parameter int ADDRWIDTH = 3,
  parameter int STAGES    = 2,
  parameter int CHECK_EN  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDRWIDTH:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDRWIDTH:0]   out_data,
  output logic                 step_err,
  output logic [7:0]           err_cnt,
  input  logic                 err_clr
);

  localparam int W   = ADDRWIDTH + 1;
  localparam int GRP = (W + STAGES - 1) / STAGES;

  // Resolves the Gray bits of group k; bits above the group are already binary.
  function automatic logic [W-1:0] resolve_group(input logic [W-1:0] d, input int k);
    logic [W-1:0] r;
    r = d;
    for (int i = W - 2; i >= 0; i--) begin
      if ((W - 1 - i) / GRP == k) r[i] = r[i+1] ^ r[i];
    end
    return r;
  endfunction

  logic [W-1:0]      st_data  [STAGES];
  logic [STAGES-1:0] st_v;
  logic [STAGES-1:0] st_mode;
  logic [STAGES-1:0] st_err;

  logic [W-1:0]      src_data [STAGES];
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_mode;
  logic [STAGES-1:0] src_err;
  logic [STAGES-1:0] ld;
  logic              ld_chain;

  logic [W-1:0]      prev_gray;
  logic              prev_vld;
  logic [W-1:0]      gray_diff;
  logic              multi_bit;
  logic              step_err_in;
  logic              accept;
  logic              err_xfer;

  // A stage may load if it is empty or the stage after it is taking its beat.
  always_comb begin
    ld       = '0;
    ld_chain = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld[k]    = ~st_v[k] | ld_chain;
      ld_chain = ld[k];
    end
  end

  assign in_ready = ld[0];
  assign accept   = in_valid & in_ready;

  assign gray_diff   = in_data ^ prev_gray;
  assign multi_bit   = |(gray_diff & (gray_diff - 1'b1));
  assign step_err_in = (CHECK_EN != 0) & ~mode & prev_vld & multi_bit;

  always_comb begin
    src_v       = '0;
    src_mode    = '0;
    src_err     = '0;
    src_data[0] = mode ? (in_data ^ (in_data >> 1)) : in_data;
    src_v[0]    = in_valid;
    src_mode[0] = mode;
    src_err[0]  = step_err_in;
    for (int k = 1; k < STAGES; k++) begin
      src_data[k] = st_data[k-1];
      src_v[k]    = st_v[k-1];
      src_mode[k] = st_mode[k-1];
      src_err[k]  = st_err[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_v    <= '0;
      st_mode <= '0;
      st_err  <= '0;
      for (int k = 0; k < STAGES; k++) st_data[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) st_v[k] <= src_v[k];
        if (ld[k] & src_v[k]) begin
          st_mode[k] <= src_mode[k];
          st_err[k]  <= src_err[k];
          st_data[k] <= src_mode[k] ? src_data[k] : resolve_group(src_data[k], k);
        end
      end
    end
  end

  // Only Gray-mode beats update the step history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray <= '0;
      prev_vld  <= 1'b0;
    end else if (accept & ~mode) begin
      prev_gray <= in_data;
      prev_vld  <= 1'b1;
    end
  end

  assign out_valid = st_v[STAGES-1];
  assign out_data  = st_data[STAGES-1];
  assign step_err  = st_err[STAGES-1];
  assign err_xfer  = out_valid & out_ready & step_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= {7'b0, err_xfer};
    end else if (err_xfer && err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_corefifo_gray_codec_pipe.sv
// Directed bench for corefifo_gray_codec_pipe; four instances (STAGES=1..4) share
// the stimulus, and the STAGES=2 instance carries the detailed checks.
module tb_corefifo_gray_codec_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;
  logic       err_clr;

  logic       ir [4];
  logic       ov [4];
  logic [3:0] od [4];
  logic       se [4];
  logic [7:0] ec [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar s = 0; s < 4; s++) begin : g_dut
    corefifo_gray_codec_pipe #(.ADDRWIDTH(3), .STAGES(s + 1), .CHECK_EN(1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (ir[s]),
      .in_data   (in_data),
      .out_valid (ov[s]),
      .out_ready (out_ready),
      .out_data  (od[s]),
      .step_err  (se[s]),
      .err_cnt   (ec[s]),
      .err_clr   (err_clr)
    );
  end

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ {1'b0, b[3:1]};
  endfunction

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    logic       acc;
    acc = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  function automatic logic [3:0] sweep_in(input int c);
    return (c < 16) ? b2g(4'(c)) : 4'(c - 16);
  endfunction

  function automatic logic [3:0] sweep_exp(input int c);
    return (c < 16) ? 4'(c) : b2g(4'(c - 16));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One isolated beat through the STAGES=2 instance.
  task automatic send_check(input logic m, input logic [3:0] d, input logic [3:0] exp_d,
                            input logic exp_e, input string tag);
    in_valid = 1'b1;
    mode     = m;
    in_data  = d;
    tick();
    chk({tag, "_lat"}, 32'(ov[1]), 0);
    in_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, 32'(ov[1]), 1);
    chk({tag, "_data"}, 32'(od[1]), 32'(exp_d));
    chk({tag, "_err"}, 32'(se[1]), 32'(exp_e));
    tick();
  endtask

  initial begin
    int idx;
    logic acc;
    mode    = 1'b0;
    in_data = '0;
    do_reset();
    chk("rst_out_valid", 32'(ov[1]), 0);
    chk("rst_out_data", 32'(od[1]), 0);
    chk("rst_step_err", 32'(se[1]), 0);
    chk("rst_err_cnt", 32'(ec[1]), 0);
    chk("rst_in_ready", 32'(ir[1]), 1);

    send_check(1'b0, 4'b1101, 4'b1001, 1'b0, "decode_1101");
    send_check(1'b1, 4'b1001, 4'b1101, 1'b0, "encode_1001");

    do_reset();
    for (int j = 0; j < 35; j++) begin
      if (j < 32) begin
        in_valid = 1'b1;
        mode     = (j >= 16);
        in_data  = sweep_in(j);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      chk($sformatf("sweep_ready_j%0d", j), 32'(ir[1]), 1);
      for (int s = 0; s < 4; s++) begin
        int c;
        c = j - s;
        if (c >= 0 && c < 32) begin
          chk($sformatf("sweep_s%0d_c%0d_valid", s + 1, c), 32'(ov[s]), 1);
          chk($sformatf("sweep_s%0d_c%0d_data", s + 1, c), 32'(od[s]), 32'(sweep_exp(c)));
          chk($sformatf("sweep_s%0d_c%0d_err", s + 1, c), 32'(se[s]), 0);
        end else if (c >= 32) begin
          chk($sformatf("sweep_s%0d_c%0d_idle", s + 1, c), 32'(ov[s]), 0);
        end
      end
    end
    tick();

    do_reset();
    send_check(1'b0, 4'b0000, 4'b0000, 1'b0, "step_a0");
    send_check(1'b0, 4'b0001, 4'b0001, 1'b0, "step_a1");
    send_check(1'b0, 4'b0011, 4'b0010, 1'b0, "step_a2");
    send_check(1'b0, 4'b0010, 4'b0011, 1'b0, "step_a3");
    send_check(1'b0, 4'b0110, 4'b0100, 1'b0, "step_a4");
    chk("step_a_cnt", 32'(ec[1]), 0);
    send_check(1'b1, 4'b1001, 4'b1101, 1'b0, "step_bin_between");
    send_check(1'b0, 4'b0100, 4'b0111, 1'b0, "step_after_bin");
    send_check(1'b0, 4'b0000, 4'b0000, 1'b0, "step_b0");
    send_check(1'b0, 4'b0011, 4'b0010, 1'b1, "step_b1");
    chk("step_b_cnt", 32'(ec[1]), 1);
    send_check(1'b0, 4'b1000, 4'b1111, 1'b1, "step_c0");
    send_check(1'b0, 4'b0000, 4'b0000, 1'b0, "wrap_1000_0000");
    send_check(1'b0, 4'b0000, 4'b0000, 1'b0, "repeat_0000");
    chk("step_c_cnt", 32'(ec[1]), 2);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    mode      = 1'b1;
    idx       = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_data = 4'(3 + idx);
      acc     = ir[1];
      tick();
      if (acc) idx++;
      if (cyc >= 1) begin
        chk($sformatf("bp_valid_%0d", cyc), 32'(ov[1]), 1);
        chk($sformatf("bp_stable_%0d", cyc), 32'(od[1]), 32'(b2g(4'd3)));
      end
    end
    chk("bp_accepted", 32'(idx), 2);
    chk("bp_in_ready", 32'(ir[1]), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_rel1_valid", 32'(ov[1]), 1);
    chk("bp_rel1_data", 32'(od[1]), 32'(b2g(4'd4)));
    tick();
    chk("bp_rel_empty", 32'(ov[1]), 0);

    in_valid = 1'b1;
    mode     = 1'b0;
    for (int k = 0; k < 300; k++) begin
      in_data = (k % 2 == 1) ? 4'b0000 : 4'b0011;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("sat_cnt", 32'(ec[1]), 255);

    in_valid = 1'b1;
    in_data  = 4'b0011;
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr_beat_err", 32'(se[1]), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_with_err", 32'(ec[1]), 1);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'b1100;
    tick();
    in_data = 4'b0011;
    tick();
    in_valid = 1'b0;
    chk("mid_inflight", 32'(ov[1]), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ov[1]), 0);
    chk("mid_rst_cnt", 32'(ec[1]), 0);
    chk("mid_rst_data", 32'(od[1]), 0);
    chk("mid_rst_ready", 32'(ir[1]), 1);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_check(1'b0, 4'b1111, 4'b1010, 1'b0, "post_rst_1111");
    chk("post_rst_cnt", 32'(ec[1]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/corefifo_gray_codec_pipe.md
# corefifo_gray_codec_pipe

Parametrised, pipelined Gray/binary code converter with a valid/ready handshake, per-beat mode select and a Gray step-error monitor. It replaces the purely combinational Gray-to-binary converter wherever the XOR chain limits timing on wide FIFO pointers. It also checks that successive Gray pointer values change by at most one bit. It sits in the COREFIFO pointer path after the pointer synchroniser and before the full/empty compare logic.

## Interface
Parameters:
- ADDRWIDTH, 3, pointer data width is ADDRWIDTH+1 bits. Legal range 1..31.
- STAGES, 2, number of register stages from input accept to output. Legal range 1..ADDRWIDTH+1.
- CHECK_EN, 1, 1 enables the Gray step-error monitor. 0 forces step_err and err_cnt to 0.

Ports:
- clk, input, 1, sole clock. All logic is rising-edge.
- rst_n, input, 1, asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronous to clk by the parent.
- mode, input, 1, sampled with each accepted beat. 0 = Gray to binary, 1 = binary to Gray.
- in_valid, input, 1, input beat present.
- in_ready, output, 1, block can accept a beat.
- in_data, input, ADDRWIDTH+1, code to convert.
- out_valid, output, 1, output beat present.
- out_ready, input, 1, downstream accepts the beat.
- out_data, output, ADDRWIDTH+1, converted code.
- step_err, output, 1, travels with the output beat. Set when that beat was a Gray-mode input differing from the previous accepted Gray-mode input in more than one bit.
- err_cnt, output, 8, saturating count of beats with step_err set that were accepted at the output.
- err_clr, input, 1, synchronous clear of err_cnt.

## Operation
- Input accept: a beat is accepted when in_valid & in_ready.
- Pipeline: an elastic chain of STAGES registers, each holding data, mode, step_err and a valid bit.
  - A stage loads when it is empty or its content moves forward in the same cycle.
  - The last stage moves forward when out_valid & out_ready.
  - in_ready = stage-0 empty, or stage 0 moving forward. This is a combinational chain back from out_ready.
- Binary to Gray (mode=1):
  - g = b ^ (b >> 1), computed before stage 0.
  - Later stages pass the value through unchanged.
- Gray to binary (mode=0):
  - b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i].
  - The chain is split MSB-first into STAGES contiguous groups of ceil((ADDRWIDTH+1)/STAGES) bits. The last group may be shorter.
  - Stage k resolves group k using the resolved LSB of group k-1 carried in its register.
  - The result is bit-identical for every legal STAGES value.
- Step monitor (CHECK_EN=1):
  - Registers prev_gray and prev_vld.
  - On an accepted mode=0 beat: step_err_in = prev_vld & (popcount(in_data ^ prev_gray) > 1). Then prev_gray <= in_data and prev_vld <= 1.
  - An accepted mode=1 beat leaves prev_gray and prev_vld unchanged and carries step_err=0.
  - The first Gray beat after reset never flags.
  - An identical repeated value (0 bits changed) is legal.
- err_cnt:
  - If err_clr is high: err_cnt <= (out_valid & out_ready & step_err) ? 1 : 0.
  - Otherwise it increments on each output transfer with step_err=1, saturating at 255.

## Timing
- Reset values: out_valid=0, out_data=0, step_err=0, err_cnt=0, all stage valids=0, prev_vld=0, prev_gray=0.
  - in_ready is 1 out of reset, since stage 0 is empty.
- Latency: a beat accepted at edge n is presented at the output (out_valid=1) after edge n+STAGES-1.
  - STAGES=1 therefore gives out_valid in the cycle following acceptance.
- Throughput: one beat per clk while out_ready=1.
- No bubbles: the pipeline holds STAGES beats when full and out_ready=0.
- Stall stability: while out_valid=1 and out_ready=0, out_data and step_err hold stable and in_ready falls once all stages are full.
- Simultaneous events:
  - Accept and output transfer in the same cycle is legal, with no loss and no duplication.
  - err_clr and a counted error in the same cycle give err_cnt=1.
- Reset mid-operation: all in-flight beats are discarded, outputs return to their reset values immediately, and monitor history is lost.
- Wrap-around: Gray 1000 followed by 0000 (ADDRWIDTH=3) is a single-bit change and does not flag.

## Test plan
- Gray decode, ADDRWIDTH=3, STAGES=2, mode=0: in_data=4'b1101 -> out_data=4'b1001 after 2 edges, step_err=0.
- Binary encode, mode=1: in_data=4'b1001 -> out_data=4'b1101. Sweep all 16 codes in both modes, back-to-back, for each STAGES in 1..4. Required: a round trip returns the original value and one beat per cycle is sustained.
- Step monitor, mode=0:
  - Sequence 0000, 0001, 0011, 0010, 0110 -> step_err all 0.
  - Sequence 0000, 0011 -> second beat step_err=1 and err_cnt=1.
  - A mode=1 beat between Gray beats does not affect flagging.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1. Required:
  - exactly STAGES beats are accepted, then in_ready=0;
  - out_data is stable while stalled;
  - after release, all beats appear in order with none dropped.
- err_cnt: inject 300 flagged beats -> err_cnt saturates at 255. Then assert err_clr together with a flagged output transfer -> err_cnt=1.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight. Required:
  - out_valid=0 and err_cnt=0 immediately;
  - after release, the first Gray beat 1111 does not flag.
